display_ram_arbiter: RTL
========================

DISPLAY_RAM_ARBITER -- requirements
Module: display_ram_arbiter

Interface
REQ-001 Parameter LO_LAST, default 8'h4F, is the last address of the lower display segment (0x00..LO_LAST).
REQ-002 Parameter HI_FIRST, default 8'h80, is the first address of the upper display segment.
REQ-003 Parameter HI_LAST, default 8'hCF, is the last address of the upper display segment.
REQ-004 clk  in  1  is the single clock; all state updates on posedge clk.
REQ-005 reset  in  1  is a synchronous, active-high reset, sampled on posedge clk.
REQ-006 cpu_en  in  1  is the CPU display-page access strobe, one cycle per access.
REQ-007 cpu_write_en  in  1  selects write (1) or read (0) when cpu_en=1.
REQ-008 cpu_addr  in  8  is the address within the 0xE00 page.
REQ-009 cpu_write_data  in  4  is the CPU write nibble.
REQ-010 cpu_read_data  out  4  is the registered CPU read result.
REQ-011 ram_we  out  1, ram_addr  out  8, ram_wdata  out  4  form the single-port display RAM command.
REQ-012 ram_rdata  in  4  is RAM read data; cycle N+1 holds the contents at the ram_addr issued in cycle N.
REQ-013 frame_start  in  1  is a one-cycle pulse that requests one full scan.
REQ-014 lcd_enable  in  1  forces scan_data to 0 when low (display blank).
REQ-015 scan_valid  out  1, scan_addr  out  8, scan_data  out  4  form the scan element stream.
REQ-016 scan_ready  in  1  is the downstream accept for the scan stream.
REQ-017 frame_done  out  1  is a one-cycle pulse at the end of a scan.
REQ-018 overrun  out  1  is a sticky flag: frame_start was received while a scan was active.

Function
REQ-019 A CPU access has absolute priority: when cpu_en=1 and cpu_addr is valid, ram_addr=cpu_addr and ram_we=cpu_write_en in that same cycle.
REQ-020 Valid addresses are 0x00..LO_LAST and HI_FIRST..HI_LAST; a write to any other address leaves ram_we=0, and a read returns 0.
REQ-021 A CPU read loads cpu_read_data from ram_rdata (or 0 for an invalid address) one cycle after cpu_en; the value is held until the next CPU read.
REQ-022 Scanner FSM states are IDLE, REQ, WAIT, OUT and DONE.
REQ-023 IDLE: frame_start moves the FSM to REQ with scan pointer 0x00.
REQ-024 REQ: if cpu_en=0, the scanner issues a read at the pointer and goes to WAIT; if cpu_en=1, it stays in REQ (stall).
REQ-025 WAIT: the scanner captures ram_rdata (or 0 if lcd_enable=0) into scan_data, then goes to OUT; a CPU access in WAIT is permitted.
REQ-026 OUT: scan_valid=1 with stable scan_addr and scan_data until a cycle in which scan_ready=1.
REQ-027 On OUT handshake: pointer LO_LAST goes to HI_FIRST, pointer HI_LAST goes to DONE, otherwise pointer+1; the FSM then returns to REQ.
REQ-028 DONE: frame_done=1 for one cycle, then IDLE.
REQ-029 Uncontended throughput is one element per 3 cycles; one frame is 160 elements.
REQ-030 frame_start outside IDLE is ignored and sets overrun; frame_start in the same cycle as DONE also sets overrun.
REQ-031 The scanner drives ram_we=0 at all times.
REQ-032 When neither requester uses the RAM: ram_we=0, ram_addr=0, ram_wdata=0.

Reset
REQ-033 Reset puts the FSM in IDLE with pointer 0x00 and drives every output to 0: cpu_read_data, ram_*, scan_*, frame_done and overrun.
REQ-034 Reset mid-scan aborts the frame without a frame_done pulse; frame_start is ignored during reset.

Verification
REQ-035 Scenario: frame_start, scan_ready=1, no CPU traffic, RAM[a]=a[3:0] -> 160 scan elements; addr 0x4F is followed by 0x80; frame_done comes 1 cycle after the 0xCF handshake; 480 cycles from REQ entry to DONE.
REQ-036 Scenario: cpu_en held high for 5 cycles while the FSM is in REQ -> the scanner stalls 5 cycles; CPU writes of 4'hA to 0x10 land in RAM; the scan sequence is unaltered.
REQ-037 Scenario: CPU write 0x50=4'h7 then read 0x50 -> ram_we stays 0; cpu_read_data=0 one cycle after the read.
REQ-038 Scenario: scan_ready=0 for 10 cycles in OUT -> scan_valid, scan_addr and scan_data are held stable; the stream advances on the first ready cycle.
REQ-039 Scenario: second frame_start mid-scan -> overrun=1 and stays 1; the scan completes normally with one frame_done.
REQ-040 Scenario: reset asserted at element 0x20 -> all outputs 0 next cycle with no frame_done; a new frame_start restarts at 0x00.

Source files
------------

// File: rtl/display_ram_arbiter.sv
// rtl/display_ram_arbiter.sv - CPU/scanner arbiter for a single-port 4-bit display RAM
//
// Purpose:
//   Shares one single-port display RAM between CPU accesses to the display
//   page and a frame scanner that streams every displayable element out.
//   The CPU always wins; the scanner stalls in its request state while the
//   CPU is using the RAM.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   cpu_en                one-cycle CPU access strobe
//   cpu_write_en          1 = write, 0 = read (qualified by cpu_en)
//   cpu_addr[7:0]         address within the display page
//   cpu_write_data[3:0]   write nibble
//   cpu_read_data[3:0]    registered read result, held until the next read
//   ram_we/ram_addr/ram_wdata   RAM command (combinational)
//   ram_rdata[3:0]        RAM data, one cycle after the address
//   frame_start           pulse requesting one full scan
//   lcd_enable            0 blanks scan data
//   scan_valid/scan_addr/scan_data, scan_ready   scan element stream
//   frame_done            one-cycle pulse after the last element
//   overrun               sticky: frame_start seen while a scan was busy

module display_ram_arbiter #(
  parameter logic [7:0] LO_LAST  = 8'h4F,
  parameter logic [7:0] HI_FIRST = 8'h80,
  parameter logic [7:0] HI_LAST  = 8'hCF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_en,
  input  logic       cpu_write_en,
  input  logic [7:0] cpu_addr,
  input  logic [3:0] cpu_write_data,
  output logic [3:0] cpu_read_data,
  output logic       ram_we,
  output logic [7:0] ram_addr,
  output logic [3:0] ram_wdata,
  input  logic [3:0] ram_rdata,
  input  logic       frame_start,
  input  logic       lcd_enable,
  output logic       scan_valid,
  output logic [7:0] scan_addr,
  output logic [3:0] scan_data,
  input  logic       scan_ready,
  output logic       frame_done,
  output logic       overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT,
    S_DONE
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_ptr;
  logic [7:0] w_ptr_next;
  logic       w_scan_issue;
  logic [3:0] r_scan_data;
  logic [3:0] r_cpu_rd;
  logic       r_rd_pend;
  logic       r_rd_addr_ok;
  logic       r_overrun;
  logic       w_addr_ok;
  logic       w_cpu_go;

  assign w_addr_ok = (cpu_addr <= LO_LAST) ||
                     ((cpu_addr >= HI_FIRST) && (cpu_addr <= HI_LAST));
  assign w_cpu_go  = cpu_en && w_addr_ok;

  // Scanner next-state. The REQ stall looks at raw cpu_en (not w_cpu_go) so
  // any CPU strobe, even to an unmapped address, holds the scanner off.
  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_scan_issue = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (frame_start) begin
          w_state_next = S_REQ;
          w_ptr_next   = 8'h00;
        end
      end
      S_REQ: begin
        if (!cpu_en) begin
          w_scan_issue = 1'b1;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        w_state_next = S_OUT;
      end
      S_OUT: begin
        if (scan_ready) begin
          if (r_ptr == HI_LAST) begin
            w_state_next = S_DONE;
          end else begin
            w_state_next = S_REQ;
            // Skip the hole between the two display segments.
            w_ptr_next   = (r_ptr == LO_LAST) ? HI_FIRST : (r_ptr + 8'd1);
          end
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // RAM command mux: CPU first, scanner read second, otherwise all zero.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = 8'h00;
    ram_wdata = 4'h0;
    if (!reset) begin
      if (w_cpu_go) begin
        ram_we    = cpu_write_en;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_write_en ? cpu_write_data : 4'h0;
      end else if (w_scan_issue) begin
        ram_addr  = r_ptr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_ptr        <= 8'h00;
      r_scan_data  <= 4'h0;
      r_cpu_rd     <= 4'h0;
      r_rd_pend    <= 1'b0;
      r_rd_addr_ok <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      // RAM data in WAIT belongs to the address issued in REQ, regardless of
      // any CPU access happening during WAIT.
      if (r_state == S_WAIT) begin
        r_scan_data <= lcd_enable ? ram_rdata : 4'h0;
      end
      // CPU read: remember the request, then load the returning data.
      r_rd_pend    <= cpu_en && !cpu_write_en;
      r_rd_addr_ok <= w_addr_ok;
      if (r_rd_pend) begin
        r_cpu_rd <= r_rd_addr_ok ? ram_rdata : 4'h0;
      end
      if (frame_start && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign scan_valid    = (r_state == S_OUT);
  assign scan_addr     = scan_valid ? r_ptr : 8'h00;
  assign scan_data     = scan_valid ? r_scan_data : 4'h0;
  assign frame_done    = (r_state == S_DONE);
  assign overrun       = r_overrun;
  assign cpu_read_data = r_cpu_rd;

endmodule
